// File: rtl/dcsk_tx_frame_ctrl.sv
// DCSK transmit frame sequencer: turns each accepted message bit into SF reference chips then SF data chips.
// Build option: define DCSK_GUARD_EN to insert GUARD_CHIPS idle chip cycles after every frame.
//
// state | meaning
// IDLE  | waiting for i_en and a message bit
// REF   | emitting reference-half chips
// DATA  | emitting data-half chips
// GUARD | post-frame gap, chaos generator still advancing (DCSK_GUARD_EN only)
module dcsk_tx_frame_ctrl #(
    parameter int unsigned GUARD_CHIPS = 2
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_en,
    input  logic [1:0] i_sf,
    input  logic       i_msg_valid,
    input  logic       i_msg_bit,
    output logic       o_msg_ready,
    output logic [1:0] o_sf,
    output logic       o_msg_bit,
    output logic       o_frame_half,
    output logic       o_chaos_en,
    output logic       o_chip_valid,
    output logic       o_frame_start,
    output logic       o_frame_end,
    output logic       o_underrun,
    output logic       o_busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REF   = 2'd1,
        DATA  = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CHIPS - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] n_last;
    logic [3:0] last_cnt;
    logic       last;
    logic       end_st;
    logic       hs;

    always_comb begin
        n_last = 4'd1;
        case (o_sf)
            2'd0: n_last = 4'd1;
            2'd1: n_last = 4'd3;
            2'd2: n_last = 4'd7;
            2'd3: n_last = 4'd15;
            default: n_last = 4'd1;
        endcase
    end

    assign last_cnt = (state == GUARD) ? GUARD_LAST : n_last;
    assign last     = (cnt == last_cnt);

    // The state whose final cycle decides between the next frame and IDLE.
`ifdef DCSK_GUARD_EN
    assign end_st = (state == GUARD);
`else
    assign end_st = (state == DATA);
`endif

    assign o_msg_ready = i_en & ((state == IDLE) | (end_st & last));
    assign hs          = o_msg_ready & i_msg_valid;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            o_sf      <= 2'd0;
            o_msg_bit <= 1'b0;
        end else begin
            if (hs) begin
                o_msg_bit <= i_msg_bit;
                o_sf      <= i_sf;
            end
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (hs) state <= REF;
                end
                REF: begin
                    if (last) begin
                        state <= DATA;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (last) begin
                        cnt <= 4'd0;
`ifdef DCSK_GUARD_EN
                        state <= GUARD;
`else
                        state <= hs ? REF : IDLE;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GUARD: begin
                    if (last) begin
                        cnt   <= 4'd0;
                        state <= hs ? REF : IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign o_busy        = (state != IDLE);
    assign o_chip_valid  = (state == REF) | (state == DATA);
    assign o_chaos_en    = (state != IDLE);
    assign o_frame_half  = (state == DATA);
    assign o_frame_start = (state == REF) & (cnt == 4'd0);
    assign o_frame_end   = (state == DATA) & last;
    assign o_underrun    = end_st & last & i_en & ~i_msg_valid;

endmodule

// File: tb/tb_dcsk_tx_frame_ctrl.sv
// Bench for dcsk_tx_frame_ctrl: directed steps push expected chips into a scoreboard, a monitor pops them.
module tb_dcsk_tx_frame_ctrl;
`ifdef DCSK_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_arst_n = 1'b1;
    logic       i_en = 1'b0;
    logic [1:0] i_sf = 2'd0;
    logic       i_msg_valid = 1'b0;
    logic       i_msg_bit = 1'b0;
    logic       o_msg_ready;
    logic [1:0] o_sf;
    logic       o_msg_bit;
    logic       o_frame_half;
    logic       o_chaos_en;
    logic       o_chip_valid;
    logic       o_frame_start;
    logic       o_frame_end;
    logic       o_underrun;
    logic       o_busy;

    int n_total = 0;
    int n_pass = 0;
    int underrun_seen = 0;
    int underrun_exp = 0;
    logic [6:0] sb_q[$];
    logic [2:0] bits = 3'b101;

    dcsk_tx_frame_ctrl #(.GUARD_CHIPS(2)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_en(i_en), .i_sf(i_sf),
        .i_msg_valid(i_msg_valid), .i_msg_bit(i_msg_bit), .o_msg_ready(o_msg_ready),
        .o_sf(o_sf), .o_msg_bit(o_msg_bit), .o_frame_half(o_frame_half),
        .o_chaos_en(o_chaos_en), .o_chip_valid(o_chip_valid), .o_frame_start(o_frame_start),
        .o_frame_end(o_frame_end), .o_underrun(o_underrun), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Expected chip word: {half, msg_bit, sf, start, end, chaos_en}
    task automatic push_frame(input logic b, input logic [1:0] s);
        int n;
        n = 2 << s;
        for (int i = 0; i < 2 * n; i++)
            sb_q.push_back({i >= n, b, s, i == 0, i == 2 * n - 1, 1'b1});
    endtask

    always @(negedge i_clk) begin
        if (i_arst_n === 1'b1) begin
            if (o_underrun === 1'b1) underrun_seen++;
            if (o_chip_valid === 1'b1) begin
                chk("chip_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0)
                    chk("chip", 32'({o_frame_half, o_msg_bit, o_sf, o_frame_start, o_frame_end, o_chaos_en}),
                        32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        #1 i_arst_n = 1'b0;
        @(negedge i_clk);
        chk("reset_outs", 32'({o_sf, o_msg_bit, o_frame_half, o_chaos_en, o_chip_valid,
                               o_frame_start, o_frame_end, o_underrun, o_busy}), 32'd0);
        cyc(1);
        i_arst_n = 1'b1;

        // SF4 single bit, then stream stops while enabled
        cyc(1);
        i_en = 1'b1; i_sf = 2'd1; i_msg_valid = 1'b1; i_msg_bit = 1'b1;
        push_frame(1'b1, 2'd1);
        @(negedge i_clk);
        chk("t1_ready", 32'(o_msg_ready), 32'd1);
        cyc(1);
        i_msg_valid = 1'b0;
        @(negedge i_clk);
        chk("t1_start", 32'({o_frame_start, o_frame_half, o_busy}), 32'b101);
        cyc(7);
        @(negedge i_clk);
        chk("t1_end", 32'({o_frame_end, o_frame_half}), 32'b11);
        chk("t1_underrun_at_end", 32'(o_underrun), 32'(G == 0));
        if (G > 0) begin
            cyc(G);
            @(negedge i_clk);
            chk("t1_underrun_guard", 32'({o_underrun, o_chip_valid}), 32'b10);
        end
        underrun_exp++;
        cyc(1);
        @(negedge i_clk);
        chk("t1_idle", 32'({o_busy, o_chip_valid, o_msg_bit, o_sf}), 32'b00101);

        // SF2 continuous stream 1,0,1, then enable dropped so no underrun
        cyc(1);
        i_sf = 2'd0; i_msg_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_msg_bit = bits[k];
            push_frame(bits[k], 2'd0);
            @(negedge i_clk);
            chk("t2_ready_hi", 32'(o_msg_ready), 32'd1);
            if (k > 0) chk("t2_bit_hold", 32'(o_msg_bit), 32'(bits[k-1]));
            cyc(1);
            if (k == 2) begin
                i_msg_valid = 1'b0; i_en = 1'b0;
            end
            @(negedge i_clk);
            chk("t2_bit_new", 32'(o_msg_bit), 32'(bits[k]));
            chk("t2_ready_lo", 32'(o_msg_ready), 32'd0);
            cyc(3 + G);
        end
        cyc(1);
        @(negedge i_clk);
        chk("t2_idle", 32'(o_busy), 32'd0);

        // SF16 frame with i_sf changed mid-frame
        cyc(1);
        i_en = 1'b1; i_msg_valid = 1'b1; i_msg_bit = 1'b0; i_sf = 2'd3;
        push_frame(1'b0, 2'd3);
        @(negedge i_clk);
        chk("t3_ready", 32'(o_msg_ready), 32'd1);
        cyc(1);
        i_msg_bit = 1'b1;
        push_frame(1'b1, 2'd0);
        @(negedge i_clk);
        chk("t3_ready_ref", 32'(o_msg_ready), 32'd0);
        cyc(5);
        i_sf = 2'd0;
        @(negedge i_clk);
        chk("t3_sf_held", 32'(o_sf), 32'd3);
        cyc(26 + G);
        @(negedge i_clk);
        chk("t3_ready_end", 32'(o_msg_ready), 32'd1);
        cyc(1);
        i_msg_valid = 1'b0; i_en = 1'b0;
        @(negedge i_clk);
        chk("t3_new_sf", 32'({o_sf, o_frame_start}), 32'b001);
        cyc(4 + G);
        @(negedge i_clk);
        chk("t3_idle", 32'(o_busy), 32'd0);

        // SF8, enable dropped in the data half with valid held
        cyc(1);
        i_en = 1'b1; i_msg_valid = 1'b1; i_msg_bit = 1'b1; i_sf = 2'd2;
        push_frame(1'b1, 2'd2);
        cyc(11);
        i_en = 1'b0;
        @(negedge i_clk);
        chk("t4_ready_data", 32'(o_msg_ready), 32'd0);
        cyc(5);
        @(negedge i_clk);
        chk("t4_end", 32'({o_frame_end, o_underrun, o_msg_ready}), 32'b100);
        cyc(1 + G);
        @(negedge i_clk);
        chk("t4_idle", 32'({o_busy, o_msg_ready}), 32'b00);
        i_msg_valid = 1'b0;

        // SF8, asynchronous reset at data chip 3
        cyc(1);
        i_en = 1'b1; i_msg_valid = 1'b1; i_msg_bit = 1'b0; i_sf = 2'd2;
        push_frame(1'b0, 2'd2);
        cyc(1);
        i_msg_valid = 1'b0;
        cyc(11);
        i_en = 1'b0;
        #2 i_arst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("t5_async_reset", 32'({o_sf, o_msg_bit, o_frame_half, o_chaos_en, o_chip_valid,
                                   o_frame_start, o_frame_end, o_underrun, o_busy}), 32'd0);
        cyc(2);
        i_arst_n = 1'b1;
        cyc(1);
        i_en = 1'b1; i_msg_valid = 1'b1; i_msg_bit = 1'b1; i_sf = 2'd0;
        push_frame(1'b1, 2'd0);
        @(negedge i_clk);
        chk("t5_ready", 32'(o_msg_ready), 32'd1);
        cyc(1);
        i_msg_valid = 1'b0; i_en = 1'b0;
        @(negedge i_clk);
        chk("t5_clean_start", 32'({o_frame_start, o_frame_half, o_msg_bit}), 32'b101);
        cyc(3);
        @(negedge i_clk);
        chk("t5_end", 32'(o_frame_end), 32'd1);
        cyc(1 + G);
        @(negedge i_clk);
        chk("t5_idle", 32'(o_busy), 32'd0);

`ifdef DCSK_GUARD_EN
        // Guard gap between back-to-back SF2 frames
        cyc(1);
        i_en = 1'b1; i_msg_valid = 1'b1; i_msg_bit = 1'b1; i_sf = 2'd0;
        push_frame(1'b1, 2'd0);
        cyc(1);
        i_msg_bit = 1'b0;
        push_frame(1'b0, 2'd0);
        cyc(4);
        @(negedge i_clk);
        chk("t6_guard0", 32'({o_chip_valid, o_chaos_en, o_frame_half, o_msg_ready}), 32'b0100);
        cyc(1);
        @(negedge i_clk);
        chk("t6_guard1", 32'({o_chip_valid, o_chaos_en, o_frame_half, o_msg_ready}), 32'b0101);
        cyc(1);
        i_msg_valid = 1'b0; i_en = 1'b0;
        @(negedge i_clk);
        chk("t6_period", 32'({o_frame_start, o_msg_bit}), 32'b10);
        cyc(6);
        @(negedge i_clk);
        chk("t6_idle", 32'(o_busy), 32'd0);
`endif

        cyc(2);
        chk("underrun_count", 32'(underrun_seen), 32'(underrun_exp));
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
